masked_state_array: RTL
=======================

# masked_state_array

Parametrised, multi-share AES state register for the time-sharing-masked datapath. It holds NSHARES independent 4x4 byte arrays and supports parallel load, byte-serial streaming (push, drain or both), and an in-place ShiftRows permutation. A fill counter and a ready/valid handshake let the block sit between the byte-serial S-box pipeline and the column-parallel MixColumns stage.

## Interface
Parameters:
- NSHARES, 2, number of Boolean shares held; each share is a full 4x4 array.
- BYTE_W, 8, width of one array element.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  global enable; low = every register and the counter hold.
- load  in  1  parallel load of all bytes from state_in.
- shift_rows  in  1  apply ShiftRows in place.
- ser_valid  in  1  push request; ser_in is valid.
- ser_ready  out  1  push accepted this cycle when ser_valid is also high.
- drain  in  1  shift out one byte per cycle, zero-filling the tail.
- ser_in  in  NSHARES*BYTE_W  pushed byte, one slice per share: share s at [s*BYTE_W +: BYTE_W].
- ser_out  out  NSHARES*BYTE_W  byte 0 of every share, same slicing as ser_in.
- state_in  in  NSHARES*16*BYTE_W  parallel input. Byte k of share s is at [(s*16+k)*BYTE_W +: BYTE_W]. k = col*4 + row, with row and col in 0..3 (column-major).
- state_out  out  NSHARES*16*BYTE_W  registered array, same layout as state_in.
- byte_count  out  5  number of valid bytes, 0..16.
- full  out  1  byte_count == 16.

## Operation
- Per-cycle priority: reset > !enable (hold all) > load > serial (push and/or drain) > shift_rows > hold.
- Reset values:
  - all state bytes 0
  - byte_count 0
  - full 0
  - ser_out 0
- load: every byte takes state_in. byte_count becomes 16. Any push, drain or shift_rows in the same cycle is ignored.
- ser_ready = enable & !load & (byte_count < 16 | drain).
- push = ser_valid & ser_ready. Applies to all shares in lockstep.
- Serial move (push or drain): byte k takes byte k+1 for k = 0..14. Byte 15 takes ser_in on a push, otherwise 0. The old byte 0 is discarded; it was visible on ser_out before the edge.
- Counter update:
  - push only: +1.
  - drain only with byte_count > 0: -1.
  - push and drain together: unchanged (streaming mode). Accepted even when full.
  - drain with byte_count == 0: no effect; the array holds and is not shifted.
- Valid bytes are right-aligned at the top. After n pushes from empty, the first pushed byte sits at index 16-n. It reaches byte 0 only when full.
- shift_rows:
  - Effective only when full = 1 and no load/push/drain is active.
  - New (row r, col c) = old (r, (c+r) mod 4), for each share independently.
  - Ignored, with the state held, when not full.
- Shares are never combined. No logic in the block mixes bytes of different shares.
- Reset mid-stream aborts the fill. byte_count goes to 0 and the partial contents are cleared.

## Timing
- All state, byte_count and full are registered and update on the clk rising edge.
- ser_out is a direct wire from the byte-0 registers, with no combinational path from inputs.
- ser_ready is combinational from enable, load, drain and byte_count.
- Load latency: 1 cycle (state_in at edge t appears on state_out after t).
- Serial fill: 16 accepted pushes from empty. full rises in the cycle after the 16th accepted push.
- Serial drain: 16 drain cycles empty a full array; each byte appears on ser_out for exactly one cycle.
- ShiftRows: 1 cycle, and can be issued every cycle while full.

## Test plan
- Reset then load: NSHARES=2, share0 byte k = k, share1 byte k = 0x80+k. Required:
  - share0 state_out bytes 0..15 = 00..0F
  - byte_count = 16, full = 1, ser_ready = 0
- ShiftRows after that load. Required:
  - share0 row1 = 05,09,0D,01
  - share0 row2 = 0A,0E,02,06
  - share0 row3 = 0F,03,07,0B
  - share1 identical plus 0x80
  - a second assertion while load is high is ignored
- Serial fill: push 0x10..0x1F (share1 = 0xA0..0xAF) with ser_valid held high. Required:
  - after 16 pushes, byte 0 = 0x10 and byte 15 = 0x1F
  - full = 1 and ser_ready = 0
  - a 17th ser_valid is not accepted and the state is unchanged
- Stream while full: drain and ser_valid both high, pushing 0x55. Required:
  - ser_out = 0x10 before the edge, then 0x11
  - byte 15 = 0x55, byte_count stays 16
- Drain to empty: 16 drain cycles. Required:
  - ser_out sequence 0x11..0x1F then 0x55, byte_count 15..0, array all zero
  - a further drain has no effect
- enable low, then reset mid-fill: after 5 pushes, drop enable with ser_valid high. Required:
  - ser_ready = 0, nothing changes
  - a synchronous reset then sets byte_count = 0, all bytes = 0, full = 0

Source files
------------

// File: rtl/masked_state_array.sv
// Multi-share AES 4x4 state register: parallel load, byte-serial push/drain and
// in-place ShiftRows. Every share is a separate instance; nothing crosses shares.

module masked_state_share #(
  parameter int BYTE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 move,
  input  logic                 push,
  input  logic                 shift,
  input  logic [BYTE_W-1:0]    ser_in,
  input  logic [16*BYTE_W-1:0] state_in,
  output logic [16*BYTE_W-1:0] state_out,
  output logic [BYTE_W-1:0]    ser_out
);
  // Byte k = col*4 + row, column-major like the port layout.
  logic [15:0][BYTE_W-1:0] st_q, st_d, st_sr, st_mv;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = (((c + r) % 4) * 4) + r;
      assign st_sr[c*4+r] = st_q[SRC];
    end
  end

  // Serial move: bytes slide toward index 0, the tail takes the pushed byte or zero.
  for (genvar k = 0; k < 15; k++) begin : g_mv
    assign st_mv[k] = st_q[k+1];
  end
  assign st_mv[15] = push ? ser_in : '0;

  always_comb begin
    st_d = st_q;
    if (load)       st_d = state_in;
    else if (move)  st_d = st_mv;
    else if (shift) st_d = st_sr;
  end

  always_ff @(posedge clk) begin
    if (reset)       st_q <= '0;
    else if (enable) st_q <= st_d;
  end

  assign state_out = st_q;
  assign ser_out   = st_q[0];
endmodule

module masked_state_array #(
  parameter int NSHARES = 2,
  parameter int BYTE_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic                         shift_rows,
  input  logic                         ser_valid,
  output logic                         ser_ready,
  input  logic                         drain,
  input  logic [NSHARES*BYTE_W-1:0]    ser_in,
  output logic [NSHARES*BYTE_W-1:0]    ser_out,
  input  logic [NSHARES*16*BYTE_W-1:0] state_in,
  output logic [NSHARES*16*BYTE_W-1:0] state_out,
  output logic [4:0]                   byte_count,
  output logic                         full
);
  logic [4:0] count_q;
  logic       not_full, push, drain_eff, move, shift;

  assign not_full  = (count_q != 5'd16);
  assign ser_ready = enable & ~load & (not_full | drain);
  assign push      = ser_valid & ser_ready;
  // Draining an empty array is a no-op: nothing shifts and the count holds.
  assign drain_eff = enable & ~load & drain & (count_q != 5'd0);
  assign move      = push | drain_eff;
  assign shift     = enable & ~load & shift_rows & ~not_full & ~push & ~drain;

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= 5'd0;
    else if (enable) begin
      if (load)                     count_q <= 5'd16;
      else if (push && !drain)      count_q <= count_q + 5'd1;
      else if (drain_eff && !push)  count_q <= count_q - 5'd1;
    end
  end

  assign byte_count = count_q;
  assign full       = ~not_full;

  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    masked_state_share #(.BYTE_W(BYTE_W)) u_share (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .move      (move),
      .push      (push),
      .shift     (shift),
      .ser_in    (ser_in[s*BYTE_W +: BYTE_W]),
      .state_in  (state_in[s*16*BYTE_W +: 16*BYTE_W]),
      .state_out (state_out[s*16*BYTE_W +: 16*BYTE_W]),
      .ser_out   (ser_out[s*BYTE_W +: BYTE_W])
    );
  end
endmodule
